// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - serial receiver line input and received-byte outputs
interface serial_rx_if;
  logic       rxd;
  logic [7:0] rxData;
  logic       rxReady;
  logic       rxFrameErr;
  logic       rxActive;

  modport master (output rxd, input rxData, rxReady, rxFrameErr, rxActive);
  modport slave  (input rxd, output rxData, rxReady, rxFrameErr, rxActive);
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 16x oversampled 8N1 receiver with 3-sample majority vote
// Bit b is decided on tick 16b+10 (samples 7,8,9), counted from the start-edge cycle.
module serial_rx #(
  parameter int TICK_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  serial_rx_if.slave rx
);
  localparam int            DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHIGH} state_t;

  state_t        state, state_nx;
  logic          sync1, rxs;
  logic [DW-1:0] div;
  logic [3:0]    samp, bit_idx;
  logic          v7, v8;
  logic [7:0]    shreg, data_q;
  logic          ready_q, ferr_q;
  logic          tick, decide, vote;
  logic          clr_cnt, shift_en, load_data, frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx.rxd;
      rxs   <= sync1;
    end
  end

  assign tick   = (div == DIV_LAST);
  assign decide = tick && (samp == 4'd9);
  assign vote   = (v7 & v8) | (v7 & rxs) | (v8 & rxs);

  // Divider realigns to the detected start edge so sample 8 lands mid-bit.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt || tick) div <= '0;
    else                          div <= div + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      samp    <= '0;
      bit_idx <= '0;
    end else if (tick && (state == START || state == DATA || state == STOP)) begin
      samp <= samp + 4'd1;
      if (samp == 4'd15) bit_idx <= bit_idx + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v7 <= 1'b1;
      v8 <= 1'b1;
    end else if (tick) begin
      if (samp == 4'd7) v7 <= rxs;
      if (samp == 4'd8) v8 <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clr_cnt   = 1'b0;
    shift_en  = 1'b0;
    load_data = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          clr_cnt  = 1'b1;
          state_nx = START;
        end
      end
      START: begin
        if (decide) state_nx = vote ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 4'd8) state_nx = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (vote) begin
            load_data = 1'b1;
            state_nx  = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nx  = WAITHIGH;
          end
        end
      end
      WAITHIGH: begin
        if (rxs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (shift_en) shreg <= {vote, shreg[7:1]};
      if (load_data) data_q <= shreg;
      ready_q <= load_data;
      ferr_q  <= frame_err;
    end
  end

  assign rx.rxData     = data_q;
  assign rx.rxReady    = ready_q;
  assign rx.rxFrameErr = ferr_q;
  assign rx.rxActive   = (state != IDLE);
endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized frame bench for serial_rx against a frame-level byte/error model
module tb_serial_rx;
  localparam int TD  = 4;
  localparam int BIT = 16 * TD;
  localparam int P16 = BIT * 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  serial_rx_if rx_if ();

  serial_rx #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_cyc = -1;
  int start_cyc;
  int act_cnt;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int obs_err = 0;
  int exp_err = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.rxReady || rx_if.rxFrameErr)
        check("pulse_excl", 32'(rx_if.rxReady & rx_if.rxFrameErr), 32'd0);
      if (rx_if.rxReady) begin
        obs_q.push_back(rx_if.rxData);
        ready_cyc = cyc;
      end
      if (rx_if.rxFrameErr) obs_err++;
    end
  end

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // p16 is the bit period in sixteenths of a clock; bad>=0 inverts 3 cycles mid-bit.
  task automatic send_frame(input logic [7:0] d, input int p16, input logic stop,
                            input int nbits, input int bad);
    logic [9:0] bits;
    int prev, nxt, len;
    bits = {stop, d, 1'b0};
    prev = 0;
    for (int i = 0; i < nbits; i++) begin
      nxt = ((i + 1) * p16) / 16;
      len = nxt - prev;
      rx_if.rxd = bits[i];
      if (i == bad) begin
        wait_cycles(len / 2 - 1);
        rx_if.rxd = ~bits[i];
        wait_cycles(3);
        rx_if.rxd = bits[i];
        wait_cycles(len - len / 2 - 2);
      end else begin
        wait_cycles(len);
      end
      prev = nxt;
    end
    if (nbits == 10) begin
      if (stop) begin
        exp_q.push_back(d);
        last_good = d;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic check_queue(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_ferr"}, obs_err, exp_err);
    obs_q.delete();
    exp_q.delete();
    obs_err = 0;
    exp_err = 0;
  endtask

  initial begin
    logic [7:0] d;
    logic st;
    int p;
    int skew[2];
    skew[0] = 989;
    skew[1] = 1060;

    rx_if.rxd = 1'b1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ready", 32'(rx_if.rxReady), 32'd0);
    check("rst_ferr", 32'(rx_if.rxFrameErr), 32'd0);
    check("rst_data", 32'(rx_if.rxData), 32'd0);
    check("rst_active", 32'(rx_if.rxActive), 32'd0);
    reset = 1'b0;
    act_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rx_if.rxActive) act_cnt++;
    end
    @(posedge clk);
    #1;
    check("idle_active", act_cnt, 0);

    start_cyc = cyc;
    send_frame(8'hA5, P16, 1'b1, 10, -1);
    wait_cycles(2 * BIT);
    check_queue("single");
    check("single_latency", ready_cyc - start_cyc, 3 + 154 * TD);
    check("single_data", 32'(rx_if.rxData), 32'hA5);

    rx_if.rxd = 1'b0;
    wait_cycles(15);
    rx_if.rxd = 1'b1;
    wait_cycles(100);
    check("glitch_active", 32'(rx_if.rxActive), 32'd0);
    check_queue("glitch");

    send_frame(8'h3C, P16, 1'b1, 10, 3);
    wait_cycles(BIT);
    check_queue("noise");
    check("noise_data", 32'(rx_if.rxData), 32'h3C);

    send_frame(8'h11, P16, 1'b1, 10, -1);
    send_frame(8'h5A, P16, 1'b0, 10, -1);
    wait_cycles(30 * BIT);
    rx_if.rxd = 1'b1;
    wait_cycles(BIT);
    check_queue("framing");
    check("framing_data", 32'(rx_if.rxData), 32'h11);
    send_frame(8'h77, P16, 1'b1, 10, -1);
    wait_cycles(BIT);
    check_queue("after_break");
    check("after_break_data", 32'(rx_if.rxData), 32'h77);

    for (int s = 0; s < 2; s++) begin
      send_frame(8'h00, skew[s], 1'b1, 10, -1);
      send_frame(8'hFF, skew[s], 1'b1, 10, -1);
      send_frame(8'h55, skew[s], 1'b1, 10, -1);
      wait_cycles(2 * BIT);
      check_queue(s == 0 ? "b2b_fast" : "b2b_slow");
    end

    send_frame(8'hC3, P16, 1'b1, 4, -1);
    rx_if.rxd = 1'b0;
    wait_cycles(BIT / 2);
    reset = 1'b1;
    rx_if.rxd = 1'b1;
    wait_cycles(5);
    check("midrst_active", 32'(rx_if.rxActive), 32'd0);
    check("midrst_data", 32'(rx_if.rxData), 32'd0);
    reset = 1'b0;
    last_good = 8'h00;
    wait_cycles(2 * BIT);
    send_frame(8'h0F, P16, 1'b1, 10, -1);
    wait_cycles(BIT);
    check_queue("midrst");
    check("midrst_new_data", 32'(rx_if.rxData), 32'h0F);

    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom_range(0, 255));
      p  = 988 + int'($urandom_range(0, 72));
      st = ($urandom_range(0, 5) != 0);
      send_frame(d, p, st, 10, -1);
      if (!st) begin
        rx_if.rxd = 1'b1;
        wait_cycles(BIT);
      end
      wait_cycles(int'($urandom_range(0, 30)));
    end
    wait_cycles(2 * BIT);
    check_queue("random");
    check("random_data", 32'(rx_if.rxData), 32'(last_good));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
